hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline hazard controller. Sequences the fetch/decode/execute datapath by generating stall, bubble and flush controls.
- Produces the registered operand forwarding selects (sel_A_in, sel_B_in, sel_shift_in) consumed by the execute stage.
- Keeps a 3-entry destination scoreboard (EX, MEM, WB) shadowing the pipeline. Detects load-use hazards, taken-branch flushes and memory freezes.

Parameters:
- FLUSH_CYCLES, 2: cycles flush stays asserted after a taken branch (1..7).
- CNT_W, 16: width of the stall_count / flush_count performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- id_valid  input  1  decode stage holds a real instruction
- id_rn  input  4  Rn read by decode instruction
- id_rm  input  4  Rm read by decode instruction
- id_rs  input  4  Rs read by decode instruction
- id_use_rn  input  1  Rn is a true source
- id_use_rm  input  1  Rm is a true source
- id_use_rs  input  1  Rs is a true source
- id_rd  input  4  destination of decode instruction
- id_wr  input  1  decode instruction writes id_rd
- id_load  input  1  decode instruction is LDR (result available only at WB)
- branch_taken  input  1  execute resolved a taken branch this cycle
- mem_busy  input  1  memory stage not ready; freeze whole pipeline
- stall_if  output  1  hold PC and IF/ID register
- stall_id  output  1  hold ID/EX register (freeze only)
- bubble_ex  output  1  load NOP into ID/EX
- flush  output  1  squash IF/ID and ID/EX contents
- sel_A_in  output  2  Rn source for EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB write-through
- sel_B_in  output  2  Rm source, same encoding
- sel_shift_in  output  2  Rs source, same encoding
- state  output  2  00 RUN, 01 LDSTALL, 10 FLUSH, 11 FREEZE
- stall_count  output  CNT_W  cycles with stall_if high, saturating
- flush_count  output  CNT_W  taken branches accepted, saturating

Behaviour:
- Reset (async):
  - State RUN; all scoreboard entries invalid.
  - sel_* = 00; all control outputs 0; counters 0.
- Scoreboard entry fields: {valid, rd, wr, load}.
- Advance occurs when not frozen:
  - WB <= MEM; MEM <= EX.
  - EX <= decode info if id_valid and no load-use and no flush; otherwise an invalid entry (bubble).
- Match rule:
  - Operand X matches entry E when use_X & E.valid & E.wr & (E.rd == X) & (X != 4'hF).
  - r15 never forwards; it always uses 00.
- Forward select:
  - Computed combinationally from ID vs scoreboard. Priority EX -> 01, then MEM -> 10, then WB -> 11, else 00.
  - Registered on advance, so the value is aligned with the instruction in EX.
  - Bubble loads sel_* = 00. Freeze holds sel_*.
- Load-use hazard: an operand matches EX with EX.load = 1.
  - RUN -> LDSTALL.
  - Same cycle: stall_if = 1 and bubble_ex = 1.
  - LDSTALL lasts exactly 1 cycle, then returns to RUN.
  - After one bubble the load sits in MEM. Since MEM.load = 1, forwarding uses the next-stage value: after advance the select is 11 (WB write-through).
- Taken branch (RUN or LDSTALL, not frozen):
  - flush = 1 combinationally in the same cycle.
  - Go to FLUSH; a counter holds flush high for FLUSH_CYCLES-1 further cycles, then returns to RUN.
  - flush_count increments once per accepted branch.
  - Branch takes priority over a simultaneous load-use: no stall, the bubble comes from the flush.
  - branch_taken during FLUSH is ignored, since the branch itself is squashed.
- Freeze:
  - mem_busy = 1 in any state -> FREEZE. stall_if = stall_id = 1; bubble_ex = 0; flush = 0.
  - Scoreboard, sel_* and the flush counter hold.
  - On mem_busy falling, return to the saved prior state with its residual counter.
  - branch_taken is sampled only when mem_busy = 0; execute holds it across the freeze.
- Priority: reset > mem_busy > branch_taken > load-use.
- stall_count increments every cycle stall_if = 1 and saturates at all-ones.
- Reset mid-stall or mid-flush: immediate return to the reset values; no residual flush cycle.

Test Plan:
- Independent ALU ops (r1 <- r2+r3, then r4 <- r5+r6) -> sel_* = 00 throughout; stall_if, flush never high.
- Back-to-back dependency (r1 <- r2+r3; r4 <- r1+r5) -> second instruction in EX has sel_A_in = 01; next gap of one (independent op between) -> 10; gap of two -> 11.
- LDR r1,[r2] then ADD r3,r1,r4 -> stall_if = bubble_ex = 1 for exactly 1 cycle, state 01; ADD in EX with sel_A_in = 11; stall_count = 1.
- branch_taken pulse with FLUSH_CYCLES = 2 -> flush high for 2 consecutive cycles, state 10 then 00; flush_count = 1; a second branch_taken during flush is ignored (count stays 1).
- mem_busy held 3 cycles during FLUSH residual cycle -> stall_if/stall_id high 3 cycles, flush low during freeze, 1 remaining flush cycle after release; stall_count += 3.
- Assert reset in LDSTALL -> all outputs 0, state 00 asynchronously; operand of r15 with matching EX entry -> sel = 00.

Source files
------------

// File: rtl/hazard_scheduler_if.sv
// Hazard scheduler bundle: decode-stage operand/destination info, branch and
// memory-busy status from the datapath, and the stall/flush/forward controls
// plus performance counters returned by the scheduler.
// Ports: master = datapath side (drives decode info), slave = hazard_scheduler.
interface hazard_scheduler_if #(
  parameter int CNT_W = 16
);
  // decode-stage instruction info
  logic             id_valid;
  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic [3:0]       id_rs;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rs;
  logic [3:0]       id_rd;
  logic             id_wr;
  logic             id_load;
  // execute / memory status
  logic             branch_taken;
  logic             mem_busy;
  // pipeline controls
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush;
  logic [1:0]       sel_A_in;
  logic [1:0]       sel_B_in;
  logic [1:0]       sel_shift_in;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
           id_rd, id_wr, id_load, branch_taken, mem_busy,
    input  stall_if, stall_id, bubble_ex, flush, sel_A_in, sel_B_in,
           sel_shift_in, state, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
           id_rd, id_wr, id_load, branch_taken, mem_busy,
    output stall_if, stall_id, bubble_ex, flush, sel_A_in, sel_B_in,
           sel_shift_in, state, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory freeze,
// and registered operand forwarding selects aligned with the instruction in EX.
// Ports: clk, reset (async, active high), bus (hazard_scheduler_if.slave).
module hazard_scheduler #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10,
    FREEZE  = 2'b11
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       wr;
    logic       load;
  } sb_entry_t;

  localparam logic [2:0] FLUSH_RESID = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;   // state to resume after a freeze
  state_e           eff_state;
  logic [2:0]       fcnt_q, fcnt_d;     // remaining flush cycles while in FLUSH
  sb_entry_t        ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       sel_a_q, sel_b_q, sel_s_q;
  logic [1:0]       fwd_a, fwd_b, fwd_s;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             stall_if_c, stall_id_c, bubble_c, flush_c, accept_br;

  function automatic logic op_match(input logic use_x, input logic [3:0] x,
                                    input sb_entry_t e);
    return use_x & e.valid & e.wr & (e.rd == x) & (x != 4'hF);
  endfunction

  // A load sitting in MEM has no EX/MEM result yet; its data is taken from
  // the WB write-through path once the consumer reaches EX.
  function automatic logic [1:0] fwd_sel(input logic use_x, input logic [3:0] x,
                                         input sb_entry_t ex, input sb_entry_t mem,
                                         input sb_entry_t wb);
    if (op_match(use_x, x, ex))       return 2'b01;
    else if (op_match(use_x, x, mem)) return mem.load ? 2'b11 : 2'b10;
    else if (op_match(use_x, x, wb))  return 2'b11;
    else                              return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(bus.id_use_rn, bus.id_rn, ex_q, mem_q, wb_q);
    fwd_b = fwd_sel(bus.id_use_rm, bus.id_rm, ex_q, mem_q, wb_q);
    fwd_s = fwd_sel(bus.id_use_rs, bus.id_rs, ex_q, mem_q, wb_q);
  end

  assign load_use = ex_q.load & (op_match(bus.id_use_rn, bus.id_rn, ex_q) |
                                 op_match(bus.id_use_rm, bus.id_rm, ex_q) |
                                 op_match(bus.id_use_rs, bus.id_rs, ex_q));

  // While frozen the saved state governs behaviour in the release cycle, so
  // any residual flush cycle is issued as soon as mem_busy drops.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    fcnt_d     = fcnt_q;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    accept_br  = 1'b0;
    eff_state  = (state_q == FREEZE) ? saved_q : state_q;

    if (bus.mem_busy) begin
      state_d    = FREEZE;
      if (state_q != FREEZE) saved_d = state_q;
      stall_if_c = 1'b1;
      stall_id_c = 1'b1;
    end else begin
      case (eff_state)
        RUN, LDSTALL: begin
          if (bus.branch_taken) begin
            flush_c   = 1'b1;
            accept_br = 1'b1;
            if (FLUSH_RESID != 3'd0) begin
              state_d = FLUSH;
              fcnt_d  = FLUSH_RESID;
            end else begin
              state_d = RUN;
            end
          end else if ((eff_state == RUN) && load_use) begin
            stall_if_c = 1'b1;
            bubble_c   = 1'b1;
            state_d    = LDSTALL;
          end else begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          // branch_taken is ignored here: the branch itself is being squashed
          flush_c = 1'b1;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ex_d = '0;
    if (bus.id_valid && !bubble_c && !flush_c) begin
      ex_d.valid = 1'b1;
      ex_d.rd    = bus.id_rd;
      ex_d.wr    = bus.id_wr;
      ex_d.load  = bus.id_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      fcnt_q      <= 3'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_a_q     <= 2'b00;
      sel_b_q     <= 2'b00;
      sel_s_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
      if (!bus.mem_busy) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= ex_d;
        // bubbles carry no operands, so they load the regfile select
        sel_a_q <= ex_d.valid ? fwd_a : 2'b00;
        sel_b_q <= ex_d.valid ? fwd_b : 2'b00;
        sel_s_q <= ex_d.valid ? fwd_s : 2'b00;
      end
      if (stall_if_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (accept_br && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  // Combinational controls are forced low while reset is held.
  assign bus.stall_if     = stall_if_c & ~reset;
  assign bus.stall_id     = stall_id_c & ~reset;
  assign bus.bubble_ex    = bubble_c & ~reset;
  assign bus.flush        = flush_c & ~reset;
  assign bus.sel_A_in     = sel_a_q;
  assign bus.sel_B_in     = sel_b_q;
  assign bus.sel_shift_in = sel_s_q;
  assign bus.state        = state_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(16)) bus ();

  hazard_scheduler #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] s;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                        input logic [3:0] rs, input logic urn, input logic urm,
                        input logic urs, input logic [3:0] rd, input logic wr,
                        input logic ld);
    bus.id_valid  = v;
    bus.id_rn     = rn;
    bus.id_rm     = rm;
    bus.id_rs     = rs;
    bus.id_use_rn = urn;
    bus.id_use_rm = urm;
    bus.id_use_rs = urs;
    bus.id_rd     = rd;
    bus.id_wr     = wr;
    bus.id_load   = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
    set_id(1'b1, rn, rm, 4'd0, 1'b1, 1'b1, 1'b0, rd, 1'b1, 1'b0);
  endtask

  task automatic ldr(input logic [3:0] rd, input logic [3:0] rn);
    set_id(1'b1, rn, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b1);
  endtask

  // Expected selects are queued as the instruction is driven and compared
  // once it has advanced into EX.
  task automatic issue(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] s);
    exp_t e;
    exp_q.push_back('{tag, a, b, s});
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_selA"}, 16'(bus.sel_A_in), 16'(e.a));
      chk({e.tag, "_selB"}, 16'(bus.sel_B_in), 16'(e.b));
      chk({e.tag, "_selS"}, 16'(bus.sel_shift_in), 16'(e.s));
    end
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) issue("nop", 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    reset            = 1'b1;
    bus.branch_taken = 1'b0;
    bus.mem_busy     = 1'b0;
    nop();
    tick();
    tick();
    chk("rst_state", 16'(bus.state), 16'h0);
    chk("rst_selA", 16'(bus.sel_A_in), 16'h0);
    chk("rst_stall_cnt", bus.stall_count, 16'h0);
    chk("rst_flush_cnt", bus.flush_count, 16'h0);
    chk("rst_stall_if", 16'(bus.stall_if), 16'h0);
    reset = 1'b0;

    // independent ALU ops
    alu(4'd1, 4'd2, 4'd3);
    settle();
    chk("indep_stall", 16'(bus.stall_if), 16'h0);
    chk("indep_flush", 16'(bus.flush), 16'h0);
    issue("indep1", 2'b00, 2'b00, 2'b00);
    alu(4'd4, 4'd5, 4'd6);
    settle();
    chk("indep2_stall", 16'(bus.stall_if), 16'h0);
    issue("indep2", 2'b00, 2'b00, 2'b00);
    drain();

    // forwarding distance 0, 1, 2
    alu(4'd1, 4'd2, 4'd3);  issue("dep0_prod", 2'b00, 2'b00, 2'b00);
    alu(4'd4, 4'd1, 4'd5);  issue("fwd_ex", 2'b01, 2'b00, 2'b00);
    drain();
    alu(4'd1, 4'd2, 4'd3);  issue("dep1_prod", 2'b00, 2'b00, 2'b00);
    alu(4'd7, 4'd8, 4'd9);  issue("dep1_gap", 2'b00, 2'b00, 2'b00);
    alu(4'd4, 4'd1, 4'd5);  issue("fwd_mem", 2'b10, 2'b00, 2'b00);
    drain();
    alu(4'd1, 4'd2, 4'd3);    issue("dep2_prod", 2'b00, 2'b00, 2'b00);
    alu(4'd7, 4'd8, 4'd9);    issue("dep2_gap1", 2'b00, 2'b00, 2'b00);
    alu(4'd10, 4'd11, 4'd12); issue("dep2_gap2", 2'b00, 2'b00, 2'b00);
    alu(4'd4, 4'd1, 4'd5);    issue("fwd_wb", 2'b11, 2'b00, 2'b00);
    drain();

    // load-use stall
    ldr(4'd1, 4'd2);
    issue("ldr", 2'b00, 2'b00, 2'b00);
    alu(4'd3, 4'd1, 4'd4);
    settle();
    chk("lu_stall_if", 16'(bus.stall_if), 16'h1);
    chk("lu_bubble", 16'(bus.bubble_ex), 16'h1);
    chk("lu_flush", 16'(bus.flush), 16'h0);
    tick();
    chk("lu_state", 16'(bus.state), 16'h1);
    chk("lu_bubble_sel", 16'(bus.sel_A_in), 16'h0);
    settle();
    chk("lu_stall_once", 16'(bus.stall_if), 16'h0);
    chk("lu_bubble_once", 16'(bus.bubble_ex), 16'h0);
    issue("lu_fwd", 2'b11, 2'b00, 2'b00);
    chk("lu_state_back", 16'(bus.state), 16'h0);
    chk("lu_stall_cnt", bus.stall_count, 16'd1);

    // taken branch, second branch during flush ignored
    nop();
    bus.branch_taken = 1'b1;
    settle();
    chk("br_flush0", 16'(bus.flush), 16'h1);
    chk("br_stall0", 16'(bus.stall_if), 16'h0);
    tick();
    chk("br_state", 16'(bus.state), 16'h2);
    chk("br_cnt", bus.flush_count, 16'd1);
    settle();
    chk("br_flush1", 16'(bus.flush), 16'h1);
    tick();
    bus.branch_taken = 1'b0;
    settle();
    chk("br_state_end", 16'(bus.state), 16'h0);
    chk("br_flush_end", 16'(bus.flush), 16'h0);
    chk("br_cnt_ignored", bus.flush_count, 16'd1);

    // freeze during the residual flush cycle
    bus.branch_taken = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    chk("fz_pre_state", 16'(bus.state), 16'h2);
    chk("fz_pre_cnt", bus.flush_count, 16'd2);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fz_stall_if", 16'(bus.stall_if), 16'h1);
      chk("fz_stall_id", 16'(bus.stall_id), 16'h1);
      chk("fz_flush", 16'(bus.flush), 16'h0);
      chk("fz_bubble", 16'(bus.bubble_ex), 16'h0);
      tick();
      chk("fz_state", 16'(bus.state), 16'h3);
    end
    bus.mem_busy = 1'b0;
    settle();
    chk("fz_resid_flush", 16'(bus.flush), 16'h1);
    chk("fz_resid_stall", 16'(bus.stall_if), 16'h0);
    tick();
    settle();
    chk("fz_state_end", 16'(bus.state), 16'h0);
    chk("fz_flush_end", 16'(bus.flush), 16'h0);
    chk("fz_stall_cnt", bus.stall_count, 16'd4);
    chk("fz_flush_cnt", bus.flush_count, 16'd2);

    // branch beats a simultaneous load-use
    ldr(4'd1, 4'd2);
    issue("ldr_br", 2'b00, 2'b00, 2'b00);
    alu(4'd3, 4'd1, 4'd4);
    bus.branch_taken = 1'b1;
    settle();
    chk("prio_stall", 16'(bus.stall_if), 16'h0);
    chk("prio_bubble", 16'(bus.bubble_ex), 16'h0);
    chk("prio_flush", 16'(bus.flush), 16'h1);
    tick();
    bus.branch_taken = 1'b0;
    nop();
    chk("prio_state", 16'(bus.state), 16'h2);
    chk("prio_flush_cnt", bus.flush_count, 16'd3);
    chk("prio_stall_cnt", bus.stall_count, 16'd4);
    tick();
    chk("prio_state_end", 16'(bus.state), 16'h0);

    // reset while in LDSTALL
    ldr(4'd1, 4'd2);
    issue("ldr_rst", 2'b00, 2'b00, 2'b00);
    alu(4'd3, 4'd1, 4'd4);
    tick();
    chk("rs_pre_state", 16'(bus.state), 16'h1);
    chk("rs_pre_cnt", bus.stall_count, 16'd5);
    reset = 1'b1;
    #1;
    chk("rs_state", 16'(bus.state), 16'h0);
    chk("rs_stall_cnt", bus.stall_count, 16'h0);
    chk("rs_flush_cnt", bus.flush_count, 16'h0);
    chk("rs_stall_if", 16'(bus.stall_if), 16'h0);
    chk("rs_bubble", 16'(bus.bubble_ex), 16'h0);
    chk("rs_flush", 16'(bus.flush), 16'h0);
    nop();
    tick();
    reset = 1'b0;

    // r15 never forwards
    alu(4'd15, 4'd2, 4'd3);
    issue("r15_prod", 2'b00, 2'b00, 2'b00);
    set_id(1'b1, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
    issue("r15_use", 2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
